bitidx_enum: RTL

//  Sequential set-bit enumerator in the bit-manipulation area of the IEU; the expanding counterpart of the

---
 rtl/bitidx_enum_pkg.sv | 20 ++
 rtl/bitidx_enum_ffs_enc.sv | 58 +++++
 rtl/bitidx_enum.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bitidx_enum_pkg.sv
// -----------------------------------------------------------------------------
// bitidx_enum_pkg
// Shared definitions for the set-bit enumerator (bit-manipulation unit).
//   bitidx_state_t : two-state walk FSM encoding (IDLE, SCAN)
//   idxw_f()       : index width for a given word width
// Optional feature macro used by the top: BITIDX_BYPASS_EN
// -----------------------------------------------------------------------------
package bitidx_enum_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } bitidx_state_t;

    // Number of bits needed to address one bit of a word of the given width.
    function automatic int idxw_f(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bitidx_enum_ffs_enc.sv
// -----------------------------------------------------------------------------
// ffs_enc
// Combinational find-first-set priority encoder.
//   i_num         : word to search
//   i_rev         : 0 -> lowest set bit, 1 -> highest set bit
//   o_idx         : index of the selected bit (0 when i_num is zero)
//   o_one_or_none : i_num has at most one bit set
// Descending mode bit-reverses the word, runs the same lowest-bit search and
// maps the result back, so only one search structure exists.
// -----------------------------------------------------------------------------
module ffs_enc
    import bitidx_enum_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int IDXW  = idxw_f(WIDTH)
) (
    input  logic [WIDTH-1:0] i_num,
    input  logic             i_rev,
    output logic [IDXW-1:0]  o_idx,
    output logic             o_one_or_none
);

    logic [WIDTH-1:0] w_swz;
    logic [IDXW-1:0]  w_lo;

    // Optional bit reversal so the search below always looks for the lowest bit.
    always_comb begin
        w_swz = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_swz[i] = i_rev ? i_num[WIDTH-1-i] : i_num[i];
        end
    end

    // Lowest set bit: scan from the top so the last hit wins.
    always_comb begin
        w_lo = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_lo = w_swz[i] ? IDXW'(i) : w_lo;
        end
    end

    // Map the reversed position back; a zero word reports index 0 in both modes.
    always_comb begin
        if (i_num == '0) begin
            o_idx = '0;
        end else if (i_rev) begin
            o_idx = IDXW'(WIDTH - 1) - w_lo;
        end else begin
            o_idx = w_lo;
        end
    end

    // Clearing the lowest set bit leaves zero iff at most one bit was set.
    always_comb begin
        o_one_or_none = ((i_num & (i_num - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
    end

endmodule

// File: rtl/bitidx_enum.sv
// -----------------------------------------------------------------------------
// bitidx_enum
// Sequential set-bit enumerator: accepts one word and emits the index of each
// set bit, one beat per cycle, ascending (Rev=0) or descending (Rev=1).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   InValid/InReady     : input word handshake; A, Rev, W64 sampled on accept
//   A                   : word to enumerate
//   Rev                 : 0 ascending (LSB first), 1 descending (MSB first)
//   W64                 : enumerate only A[31:0]
//   Abort               : drop the current word; wins over every handshake
//   OutValid/OutReady   : index beat handshake
//   Idx, Ordinal        : bit index and beat number within the word
//   Last                : final beat of the word
//   Empty               : word had no set bits (single beat, Idx=0, Last=1)
// Configuration macro: BITIDX_BYPASS_EN -- when defined, a new word may be
// accepted in the cycle of the final beat so words stream without a bubble.
// -----------------------------------------------------------------------------
module bitidx_enum
    import bitidx_enum_pkg::*;
#(
    parameter  int WIDTH = 64,
    localparam int IDXW  = idxw_f(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic             Rev,
    input  logic             W64,
    input  logic             Abort,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [IDXW-1:0]  Idx,
    output logic [IDXW:0]    Ordinal,
    output logic             Last,
    output logic             Empty
);

    // Low-half mask; collapses to all ones when WIDTH is 32 so W64 is a no-op.
    localparam logic [WIDTH-1:0] LOW32_MASK = WIDTH'(32'hFFFF_FFFF);

    bitidx_state_t    r_state;
    logic [WIDTH-1:0] r_rem;
    logic             r_revq;
    logic [IDXW:0]    r_ord;

    logic [IDXW-1:0]  w_idx;
    logic             w_one;
    logic             w_scan;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_word;

    ffs_enc #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_ffs_enc (
        .i_num         (r_rem),
        .i_rev         (r_revq),
        .o_idx         (w_idx),
        .o_one_or_none (w_one)
    );

    assign w_scan = (r_state == SCAN);
    assign w_word = W64 ? (A & LOW32_MASK) : A;

    // Input readiness; the bypass form overlaps the next accept with the final beat.
    always_comb begin
`ifdef BITIDX_BYPASS_EN
        w_in_ready = ~w_scan | (w_one & OutReady & ~Abort);
`else
        w_in_ready = ~w_scan;
`endif
    end

    // Abort blocks acceptance even though IDLE still advertises InReady.
    assign w_accept = InValid & w_in_ready & ~Abort;
    assign InReady  = w_in_ready;

    // Walk FSM with remaining-bits, direction and beat-count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_revq  <= 1'b0;
            r_ord   <= '0;
        end else if (Abort) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_ord   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SCAN;
                        r_rem   <= w_word;
                        r_revq  <= Rev;
                        r_ord   <= '0;
                    end
                end
                SCAN: begin
                    if (OutReady) begin
                        if (w_one) begin
                            // Final beat: either chain straight into the next word or drain.
                            if (w_accept) begin
                                r_state <= SCAN;
                                r_rem   <= w_word;
                                r_revq  <= Rev;
                                r_ord   <= '0;
                            end else begin
                                r_state <= IDLE;
                                r_rem   <= '0;
                                r_ord   <= '0;
                            end
                        end else begin
                            r_rem <= r_rem & ~({{(WIDTH-1){1'b0}}, 1'b1} << w_idx);
                            r_ord <= r_ord + {{IDXW{1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rem   <= '0;
                    r_ord   <= '0;
                end
            endcase
        end
    end

    // Beat outputs decode the registered walk state; zero while idle.
    always_comb begin
        if (w_scan) begin
            OutValid = 1'b1;
            Idx      = w_idx;
            Last     = w_one;
            Empty    = (r_rem == '0);
        end else begin
            OutValid = 1'b0;
            Idx      = '0;
            Last     = 1'b0;
            Empty    = 1'b0;
        end
    end

    assign Ordinal = r_ord;

endmodule
